modmul_iterative: RTL and testbench

- Parametrised multi-cycle modular arithmetic unit over the pseudo-Mersenne prime p = 2^W − C. Default is p = 2^255 − 19.
- Successor to the single-cycle modular multiplier. It processes the y operand D bits per cycle (MSB-first interleaved multiply-and-fold), which trades latency for area.
- Adds modular ADD and SUB modes and a valid/ready handshake with back-pressure, so it can sit inside the point-arithmetic datapath.

---
 rtl/modmul_iterative.sv | 116 +++++++++++
 tb/tb_modmul_iterative.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/modmul_iterative.sv
// Multi-cycle MUL/ADD/SUB modulo p = 2^W - C with valid/ready handshake.
// MUL consumes y MSB-first, D bits per cycle, keeping acc partially reduced below 2^W.
module modmul_iterative #(
  parameter int unsigned W = 255,
  parameter int unsigned C = 19,
  parameter int unsigned D = 32
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [1:0]   i_op,
  input  logic [W-1:0] i_x,
  input  logic [W-1:0] i_y,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [W-1:0] o_mul
);

  localparam int unsigned NDIG = (W + D - 1) / D;
  localparam int unsigned YW   = NDIG * D;
  localparam int unsigned VW   = W + D + 1;
  localparam int unsigned CW   = $clog2(NDIG + 1);
  localparam logic [VW-1:0] P  = (VW'(1) << W) - VW'(C);
  localparam logic [VW-1:0] P2 = P << 1;

  typedef enum logic [1:0] {IDLE, MUL, FINAL, DONE} state_t;

  state_t          state, state_next;
  logic [W-1:0]    x;
  logic [W-1:0]    acc;
  logic [W-1:0]    acc_next;
  logic [YW-1:0]   y_sh;
  logic [1:0]      op;
  logic [CW-1:0]   cnt;
  logic [D-1:0]    digit;
  logic [VW-1:0]   prod;
  logic [VW-1:0]   r;

  function automatic logic [VW-1:0] fold(input logic [VW-1:0] v);
    return VW'(v[W-1:0]) + VW'(C) * (v >> W);
  endfunction

  assign o_ready = (state == IDLE);
  assign digit   = y_sh[YW-1 -: D];

  always_comb begin
    state_next = state;
    acc_next   = acc;
    prod       = '0;
    r          = '0;
    unique case (state)
      IDLE: begin
        if (i_valid) state_next = (i_op == 2'b01 || i_op == 2'b10) ? FINAL : MUL;
      end
      MUL: begin
        prod     = (VW'(acc) << D) + VW'(x) * VW'(digit);
        // Two folds always bring the W+D+1 bit sum back below 2^W.
        acc_next = W'(fold(fold(prod)));
        if (cnt == CW'(NDIG - 1)) state_next = FINAL;
      end
      FINAL: begin
        case (op)
          2'b01:   r = fold(fold(VW'(x) + VW'(y_sh[W-1:0])));
          2'b10:   r = fold(fold(VW'(x) + P2 - VW'(y_sh[W-1:0])));
          default: r = VW'(acc);
        endcase
        if (r >= P) r = r - P;
        if (r >= P) r = r - P;
        state_next = DONE;
      end
      DONE: begin
        if (i_ready) state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state   <= IDLE;
      o_valid <= 1'b0;
      o_mul   <= '0;
      x       <= '0;
      y_sh    <= '0;
      op      <= '0;
      acc     <= '0;
      cnt     <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (i_valid) begin
            x    <= i_x;
            y_sh <= YW'(i_y);
            op   <= i_op;
            acc  <= '0;
            cnt  <= '0;
          end
        end
        MUL: begin
          acc  <= acc_next;
          y_sh <= y_sh << D;
          cnt  <= cnt + 1'b1;
        end
        FINAL: begin
          o_mul   <= r[W-1:0];
          o_valid <= 1'b1;
        end
        DONE: begin
          if (i_ready) o_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_modmul_iterative.sv
// Directed and golden-model checks of modmul_iterative at D=32, D=64 and a tiny W=8 field.
module tb_modmul_iterative;

  localparam int unsigned W = 255;

  logic         clk = 1'b0;
  logic         rst_n, valid, ready_in;
  logic [1:0]   op;
  logic [W-1:0] x, y;
  logic         ready0, valid0, ready1, valid1;
  logic [W-1:0] mul0, mul1;

  logic         s_valid, s_ready_in, s_ready, s_ovalid;
  logic [1:0]   s_op;
  logic [7:0]   s_x, s_y, s_mul;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  modmul_iterative dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .o_ready(ready0), .i_op(op),
    .i_x(x), .i_y(y), .o_valid(valid0), .i_ready(ready_in), .o_mul(mul0)
  );

  modmul_iterative #(.W(255), .C(19), .D(64)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .o_ready(ready1), .i_op(op),
    .i_x(x), .i_y(y), .o_valid(valid1), .i_ready(ready_in), .o_mul(mul1)
  );

  modmul_iterative #(.W(8), .C(5), .D(3)) dut2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(s_valid), .o_ready(s_ready), .i_op(s_op),
    .i_x(s_x), .i_y(s_y), .o_valid(s_ovalid), .i_ready(s_ready_in), .o_mul(s_mul)
  );

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] gold(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [511:0] pp, aa, bb, rr;
    pp = (512'd1 << 255) - 512'd19;
    aa = 512'(a) % pp;
    bb = 512'(b) % pp;
    case (o)
      2'b01:   rr = (aa + bb) % pp;
      2'b10:   rr = (aa + pp - bb) % pp;
      default: rr = (aa * bb) % pp;
    endcase
    return rr[W-1:0];
  endfunction

  task automatic do_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] r0, output logic [W-1:0] r1,
                       output int l0, output int l1, output bit rdy);
    @(negedge clk);
    op = o; x = a; y = b; valid = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0;
    l0 = -1; l1 = -1; r0 = '0; r1 = '0;
    rdy = ready0 | ready1;
    for (int c = 1; c <= 30 && (l0 < 0 || l1 < 0); c++) begin
      @(posedge clk); #1;
      if (ready0 || ready1) rdy = 1'b1;
      if (l0 < 0 && valid0) begin l0 = c; r0 = mul0; end
      if (l1 < 0 && valid1) begin l1 = c; r1 = mul1; end
    end
    @(negedge clk); ready_in = 1'b1;
    @(posedge clk); #1; ready_in = 1'b0;
  endtask

  task automatic run_check(input string tag, input logic [1:0] o, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic [W-1:0] exp);
    logic [W-1:0] r0, r1;
    int l0, l1;
    bit rdy;
    do_op(o, a, b, r0, r1, l0, l1, rdy);
    check({tag, "_d32"}, r0, exp);
    check({tag, "_d64"}, r1, exp);
    check({tag, "_lat32"}, l0, (o == 2'b01 || o == 2'b10) ? 1 : 9);
    check({tag, "_lat64"}, l1, (o == 2'b01 || o == 2'b10) ? 1 : 5);
    check({tag, "_busy_ready"}, rdy, 1'b0);
  endtask

  task automatic do_op8(input logic [1:0] o, input logic [7:0] a, input logic [7:0] b,
                        output logic [7:0] r, output int l);
    @(negedge clk);
    s_op = o; s_x = a; s_y = b; s_valid = 1'b1;
    @(posedge clk); #1;
    s_valid = 1'b0;
    l = -1; r = '0;
    for (int c = 1; c <= 20 && l < 0; c++) begin
      @(posedge clk); #1;
      if (s_ovalid) begin l = c; r = s_mul; end
    end
    @(negedge clk); s_ready_in = 1'b1;
    @(posedge clk); #1; s_ready_in = 1'b0;
  endtask

  initial begin
    logic [W-1:0] p, a, b;
    logic [511:0] t;
    logic [1:0]   o;
    logic [7:0]   r8;
    int           l8, e8;
    int           ys [8] = '{0, 1, 2, 5, 250, 251, 254, 255};

    p = '1;
    p = p - 255'd18;
    rst_n = 1'b0; valid = 1'b0; ready_in = 1'b0; op = '0; x = '0; y = '0;
    s_valid = 1'b0; s_ready_in = 1'b0; s_op = '0; s_x = '0; s_y = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", valid0, 1'b0);
    check("rst_mul", mul0, '0);
    check("rst_ready", ready0, 1'b1);
    check("rst_ready_small", s_ready, 1'b1);
    @(negedge clk); rst_n = 1'b1;

    run_check("mul_pm1_pm1", 2'b00, p - 1, p - 1, 1);
    run_check("mul_2_half", 2'b00, 2, (p + 1) >> 1, 1);
    run_check("mul_noncanon", 2'b00, '1, 1, 18);
    run_check("mul_zero", 2'b00, 0, p - 1, 0);
    run_check("mul_op11", 2'b11, 3, 4, 12);
    run_check("add_wrap", 2'b01, p - 1, 5, 4);
    run_check("sub_neg", 2'b10, 3, 5, p - 2);
    run_check("sub_eq", 2'b10, 7, 7, 0);
    run_check("sub_noncanon", 2'b10, '1, 18, 0);

    // back-pressure: result must hold while i_ready stays low
    @(negedge clk); op = 2'b01; x = 100; y = 23; valid = 1'b1;
    @(posedge clk); #1; valid = 1'b0;
    @(posedge clk); #1;
    check("bp_valid_rise", valid0, 1'b1);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check("bp_hold_valid", valid0, 1'b1);
      check("bp_hold_mul", mul0, 123);
      check("bp_hold_ready", ready0, 1'b0);
    end
    @(negedge clk); ready_in = 1'b1;
    @(posedge clk); #1; ready_in = 1'b0;
    check("bp_drop_valid", valid0, 1'b0);
    check("bp_ready_back", ready0, 1'b1);
    check("bp_mul_retained", mul0, 123);
    run_check("bp_next", 2'b01, 10, 20, 30);

    // reset in the middle of a MUL discards it
    @(negedge clk); op = 2'b00; x = 5; y = 6; valid = 1'b1;
    @(posedge clk); #1; valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b0;
    @(posedge clk); #1;
    check("midrst_valid", valid0, 1'b0);
    check("midrst_mul", mul0, '0);
    check("midrst_ready", ready0, 1'b1);
    @(negedge clk); rst_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    check("midrst_no_output", valid0, 1'b0);
    run_check("after_rst_mul", 2'b00, 3, 4, 12);

    for (int n = 0; n < 300; n++) begin
      t = '0;
      for (int k = 0; k < 8; k++) t = {t[479:0], $urandom()};
      a = t[254:0];
      t = '0;
      for (int k = 0; k < 8; k++) t = {t[479:0], $urandom()};
      b = t[254:0];
      o = 2'($urandom_range(0, 3));
      run_check("rand", o, a, b, gold(o, a, b));
    end

    for (int oi = 0; oi < 3; oi++) begin
      for (int xv = 0; xv < 256; xv++) begin
        for (int yi = 0; yi < 8; yi++) begin
          case (oi)
            0:       e8 = (xv * ys[yi]) % 251;
            1:       e8 = (xv + ys[yi]) % 251;
            default: e8 = ((xv % 251) - (ys[yi] % 251) + 251) % 251;
          endcase
          do_op8(2'(oi), 8'(xv), 8'(ys[yi]), r8, l8);
          check("w8_result", r8, e8);
          check("w8_latency", l8, (oi == 0) ? 4 : 1);
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
